// File: rtl/neuron_potential_decay_pkg.sv
// Shared float field layout and sweep FSM encoding for the
// neuron potential datapath.
package neuron_potential_decay_pkg;

  localparam int FP_W    = 32;
  localparam int EXP_MSB = 30;
  localparam int EXP_LSB = 23;

  localparam logic [7:0]      EXP_MAX = 8'hFF;
  localparam logic [FP_W-1:0] FP_ZERO = '0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SWEEP,
    ST_LAST,
    ST_DONE
  } state_t;

endpackage

// File: rtl/fp_pow2_decay.sv
// Multiply a single-precision value by 2^-DECAY_SHIFT via the
// exponent field; small results flush to signed zero.
module fp_pow2_decay
  import neuron_potential_decay_pkg::*;
#(
  parameter int DECAY_SHIFT = 1
) (
  input  logic [FP_W-1:0] din,
  output logic [FP_W-1:0] dout
);

  localparam logic [7:0] SH = 8'(DECAY_SHIFT);

  logic [7:0] exp_in;
  logic       sgn;

  assign exp_in = din[EXP_MSB:EXP_LSB];
  assign sgn    = din[FP_W-1];

  always_comb begin
    dout = din;
    if (DECAY_SHIFT == 0) begin
      dout = din;
    end else if (exp_in == EXP_MAX) begin
      dout = din;
    end else if (exp_in <= SH) begin
      // covers zero and denormals as well
      dout = {sgn, {(FP_W-1){1'b0}}};
    end else begin
      dout = {sgn, exp_in - SH, din[EXP_LSB-1:0]};
    end
  end

endmodule

// File: rtl/neuron_potential_decay.sv
// Membrane potential store: takes adder writebacks and sweeps all
// neurons each timestep, emitting decayed potentials.
module neuron_potential_decay
  import neuron_potential_decay_pkg::*;
#(
  parameter int          NEURONS     = 16,
  parameter int          ID_W        = 4,
  parameter int          DECAY_SHIFT = 1,
  parameter logic [31:0] V_RESET     = 32'h0000_0000
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic            timestep_start,
  output logic            busy,
  output logic            done,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [ID_W-1:0] dec_id,
  output logic [31:0]     decayed_potential,
  input  logic            wb_valid,
  input  logic [ID_W-1:0] wb_id,
  input  logic [31:0]     wb_potential,
  input  logic            wb_spike
);

  localparam logic [ID_W-1:0] LAST_IDX = ID_W'(NEURONS - 1);

  logic [31:0]     mem [NEURONS];
  state_t          state;
  logic [ID_W-1:0] idx;
  logic [31:0]     wb_data;
  logic [31:0]     rd_raw;
  logic [31:0]     rd_dec;
  logic            load;

  assign wb_data = wb_spike ? V_RESET : wb_potential;
  // same-cycle writeback to the entry being read wins
  assign rd_raw  = (wb_valid && wb_id == idx) ? wb_data : mem[idx];
  assign load    = !dec_valid || dec_ready;

  fp_pow2_decay #(
    .DECAY_SHIFT(DECAY_SHIFT)
  ) u_decay (
    .din (rd_raw),
    .dout(rd_dec)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < NEURONS; i++) mem[i] <= V_RESET;
    end else if (wb_valid) begin
      mem[wb_id] <= wb_data;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state             <= ST_IDLE;
      idx               <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
      dec_valid         <= 1'b0;
      dec_id            <= '0;
      decayed_potential <= FP_ZERO;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (busy) begin
            busy <= 1'b0;
          end else if (timestep_start) begin
            busy              <= 1'b1;
            dec_valid         <= 1'b1;
            dec_id            <= idx;
            decayed_potential <= rd_dec;
            idx               <= idx + 1'b1;
            state             <= ST_SWEEP;
          end
        end
        ST_SWEEP: begin
          if (load) begin
            dec_valid         <= 1'b1;
            dec_id            <= idx;
            decayed_potential <= rd_dec;
            if (idx == LAST_IDX) state <= ST_LAST;
            else idx <= idx + 1'b1;
          end
        end
        ST_LAST: begin
          if (dec_ready) begin
            dec_valid <= 1'b0;
            idx       <= '0;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
